port_dev: RTL and testbench

Peripheral-side endpoint of the CPU register file's bidirectional `PORT` bus. Captures bytes the CPU writes onto `PORT` into a receive FIFO for an external consumer, and drives bytes loaded by an external producer onto `PORT` when the CPU reads. It sits outside the CPU core, wired directly to the register file's `PORT` pins plus two strobes decoded from the port-write and port-read register selects.

---
 rtl/port_dev_pkg.sv | 15 +
 rtl/port_dev_fifo.sv | 48 ++++
 rtl/port_dev.sv | 110 +++++++++++
 tb/tb_port_dev.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/port_dev_pkg.sv
// Shared constants for the PORT-bus peripheral endpoint: status word bit
// positions and the default FIFO depth.
package port_dev_pkg;

    localparam int DEPTH_DEFAULT = 4;

    // Bit positions inside the status word returned on an empty-TX read
    localparam int ST_OVF = 7;
    localparam int ST_UDF = 6;
    localparam int ST_RXF = 5;
    localparam int ST_RXE = 4;
    localparam int ST_TXF = 3;
    localparam int ST_TXE = 2;

endpackage

// File: rtl/port_dev_fifo.sv
// Synchronous FIFO with registered storage and a combinational head view.
// Latency: a push is visible at head one cycle later; pop takes effect at the edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module port_dev_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal)
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/port_dev.sv
// Peripheral endpoint of the register file's PORT bus: CPU writes fill RX, CPU reads drain TX.
// Latency: CPU write -> RX_VALID 1 cycle; TX accept -> PORT 1 cycle; PORT drive enable is combinational.
// Backpressure: RX full drops CPU writes (OVF); TX empty reads repeat last byte (UDF). Macro PORT_DEV_STATUS_EN.
module port_dev
    import port_dev_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    inout  wire  [WIDTH-1:0] PORT,
    input  logic             PORT_WR,
    input  logic             PORT_RD,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    input  logic             RX_READY,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic             OVF,
    output logic             UDF
);

    logic             wr_q;
    logic             rd_q;
    logic             ovf_q;
    logic             udf_q;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] tx_head;
    logic [WIDTH-1:0] drive_val;
    logic             rx_full;
    logic             rx_empty;
    logic             tx_full;
    logic             tx_empty;
    logic             wr_ev;
    logic             rd_ev;
    logic             drive_en;

    // One event per strobe assertion; the CPU owns the bus when both strobes are high
    assign wr_ev    = PORT_WR & ~wr_q;
    assign rd_ev    = PORT_RD & ~PORT_WR & ~rd_q;
    assign drive_en = PORT_RD & ~PORT_WR;
    assign PORT     = drive_en ? drive_val : {WIDTH{1'bz}};

    assign RX_VALID = ~rx_empty;
    assign TX_READY = ~tx_full;
    assign OVF      = ovf_q;
    assign UDF      = udf_q;

    port_dev_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (wr_ev),
        .push_dat (PORT),
        .pop      (RX_READY),
        .head     (RX_DATA),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    port_dev_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (TX_VALID & ~tx_full),
        .push_dat (TX_DATA),
        .pop      (rd_ev),
        .head     (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

`ifdef PORT_DEV_STATUS_EN
    logic [WIDTH-1:0] status_word;

    always_comb begin
        status_word         = '0;
        status_word[ST_OVF] = ovf_q;
        status_word[ST_UDF] = udf_q;
        status_word[ST_RXF] = rx_full;
        status_word[ST_RXE] = rx_empty;
        status_word[ST_TXF] = tx_full;
        status_word[ST_TXE] = tx_empty;
    end

    assign drive_val = tx_empty ? status_word : tx_head;
`else
    assign drive_val = tx_empty ? last_q : tx_head;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            last_q <= '0;
        end else begin
            wr_q <= PORT_WR;
            rd_q <= PORT_RD;
            // A full RX still accepts the write when the consumer pops in the same cycle
            if (wr_ev && rx_full && !RX_READY) ovf_q <= 1'b1;
            if (rd_ev) begin
                if (tx_empty) udf_q  <= 1'b1;
                else          last_q <= tx_head;
            end
        end
    end

endmodule

// File: tb/tb_port_dev.sv
// Bench for port_dev: queue-based reference model checked every cycle plus directed literal checks.
module tb_port_dev;

    localparam int W = 8;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         RST_N;
    wire  [W-1:0] PORT;
    logic         PORT_WR;
    logic         PORT_RD;
    logic [W-1:0] RX_DATA;
    logic         RX_VALID;
    logic         RX_READY;
    logic [W-1:0] TX_DATA;
    logic         TX_VALID;
    logic         TX_READY;
    logic         OVF;
    logic         UDF;

    logic         cpu_drv;
    logic [W-1:0] cpu_dat;

    assign PORT = cpu_drv ? cpu_dat : {W{1'bz}};

    always #5 CLK = ~CLK;

    port_dev #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PORT     (PORT),
        .PORT_WR  (PORT_WR),
        .PORT_RD  (PORT_RD),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .OVF      (OVF),
        .UDF      (UDF)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queues and flags updated from the bus rules
    logic [W-1:0] rx_q[$];
    logic [W-1:0] tx_q[$];
    logic [W-1:0] m_last;
    logic         m_ovf, m_udf, m_prev_wr, m_prev_rd;
    bit           started = 0;

    always @(posedge CLK) begin
        bit rx_pop, tx_push, wr_ev, rd_ev;
        started = 1;
        if (!RST_N) begin
            rx_q.delete();
            tx_q.delete();
            m_last = '0; m_ovf = 0; m_udf = 0; m_prev_wr = 0; m_prev_rd = 0;
        end else begin
            rx_pop  = RX_READY && (rx_q.size() > 0);
            tx_push = TX_VALID && (tx_q.size() < D);
            wr_ev   = PORT_WR && !m_prev_wr;
            rd_ev   = PORT_RD && !PORT_WR && !m_prev_rd;
            if (rx_pop) void'(rx_q.pop_front());
            if (wr_ev) begin
                if (rx_q.size() < D) rx_q.push_back(cpu_dat);
                else                 m_ovf = 1;
            end
            if (rd_ev) begin
                if (tx_q.size() > 0) m_last = tx_q.pop_front();
                else                 m_udf = 1;
            end
            if (tx_push) tx_q.push_back(TX_DATA);
            m_prev_wr = PORT_WR;
            m_prev_rd = PORT_RD;
        end
    end

    function automatic logic [W-1:0] exp_drive();
        if (tx_q.size() > 0) return tx_q[0];
`ifdef PORT_DEV_STATUS_EN
        return {m_ovf, m_udf, rx_q.size() == D, rx_q.size() == 0, 1'b0, 1'b1, 2'b00};
`else
        return m_last;
`endif
    endfunction

    always @(negedge CLK) begin
        if (started) begin
            chk("rx_valid", RX_VALID, rx_q.size() > 0);
            chk("rx_data", RX_DATA, (rx_q.size() > 0) ? rx_q[0] : '0);
            chk("tx_ready", TX_READY, tx_q.size() < D);
            chk("ovf", OVF, m_ovf);
            chk("udf", UDF, m_udf);
            if (cpu_drv)
                chk("port_cpu", PORT, cpu_dat);
            else if (PORT_RD && !PORT_WR)
                chk("port_dev", PORT, exp_drive());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic cpu_write(input logic [W-1:0] v);
        cpu_drv = 1; cpu_dat = v; PORT_WR = 1;
        cyc(1);
        PORT_WR = 0; cpu_drv = 0;
        cyc(1);
    endtask

    task automatic cpu_read(output logic [W-1:0] v);
        PORT_RD = 1;
        @(negedge CLK);
        v = PORT;
        cyc(1);
        PORT_RD = 0;
        cyc(1);
    endtask

    task automatic tx_push(input logic [W-1:0] v);
        TX_VALID = 1; TX_DATA = v;
        cyc(1);
        TX_VALID = 0; TX_DATA = '0;
    endtask

    logic [W-1:0] rv;

    initial begin
        RST_N = 0; PORT_WR = 0; PORT_RD = 0; RX_READY = 0;
        TX_DATA = '0; TX_VALID = 0; cpu_drv = 0; cpu_dat = '0;
        cyc(2);
        @(negedge CLK);
        chk("reset_rx_valid", RX_VALID, 0);
        chk("reset_rx_data", RX_DATA, 0);
        chk("reset_tx_ready", TX_READY, 1);
        chk("reset_ovf_udf", {OVF, UDF}, 0);
        cyc(1);
        RST_N = 1;
        cyc(1);

        // Single write held for five cycles yields one entry
        cpu_drv = 1; cpu_dat = 8'hDE; PORT_WR = 1;
        cyc(5);
        PORT_WR = 0; cpu_drv = 0;
        @(negedge CLK);
        chk("single_wr_data", RX_DATA, 8'hDE);
        chk("single_wr_valid", RX_VALID, 1);
        cyc(1);
        RX_READY = 1; cyc(1); RX_READY = 0;
        @(negedge CLK);
        chk("single_wr_once", RX_VALID, 0);
        cyc(1);

        // Read order and last value
        tx_push(8'hAB);
        tx_push(8'hDC);
        cpu_read(rv); chk("read1", rv, 8'hAB);
        cpu_read(rv); chk("read2", rv, 8'hDC);
        cpu_read(rv);
`ifndef PORT_DEV_STATUS_EN
        chk("read3_last", rv, 8'hDC);
`endif
        chk("read3_udf", UDF, 1);

        // Overflow: five writes into a four-deep RX
        for (int i = 1; i <= 5; i++) cpu_write(W'(i));
        chk("ovf_set", OVF, 1);
        RX_READY = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            chk("drain_order", RX_DATA, i);
            cyc(1);
        end
        RX_READY = 0;
        @(negedge CLK);
        chk("drain_empty", RX_VALID, 0);
        cyc(1);

        // Contention: CPU wins, TX kept, write captured
        tx_push(8'h55);
        cpu_drv = 1; cpu_dat = 8'h77; PORT_WR = 1; PORT_RD = 1;
        @(negedge CLK);
        chk("contend_port", PORT, 8'h77);
        cyc(2);
        PORT_WR = 0; PORT_RD = 0; cpu_drv = 0;
        cyc(1);
        chk("contend_capture", RX_DATA, 8'h77);
        cpu_read(rv); chk("contend_tx_kept", rv, 8'h55);
        RX_READY = 1; cyc(1); RX_READY = 0; cyc(1);

`ifdef PORT_DEV_STATUS_EN
        // OVF and UDF both set, RX and TX empty
        cpu_read(rv); chk("status_word", rv, 8'hD4);
`endif

        // Reset mid-operation with three entries each side
        for (int i = 0; i < 3; i++) cpu_write(8'h30 + W'(i));
        for (int i = 0; i < 3; i++) tx_push(8'h40 + W'(i));
        chk("pre_reset_ovf", OVF, 1);
        RST_N = 0; cyc(1); RST_N = 1;
        @(negedge CLK);
        chk("mid_reset_rx_valid", RX_VALID, 0);
        chk("mid_reset_tx_ready", TX_READY, 1);
        chk("mid_reset_flags", {OVF, UDF}, 0);
        cyc(1);
        cpu_read(rv);
`ifndef PORT_DEV_STATUS_EN
        chk("mid_reset_last", rv, 0);
`endif

        // Strobe held through reset release produces one event
        cpu_drv = 1; cpu_dat = 8'h99; PORT_WR = 1;
        RST_N = 0; cyc(1); RST_N = 1; cyc(1);
        @(negedge CLK);
        chk("held_strobe_data", RX_DATA, 8'h99);
        cyc(3);
        PORT_WR = 0; cpu_drv = 0;
        RX_READY = 1; cyc(1); RX_READY = 0;
        @(negedge CLK);
        chk("held_strobe_once", RX_VALID, 0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
